rv32_mod_load_store_unit: RTL and testbench
===========================================

# rv32_mod_load_store_unit

Load/store unit for the rv32imc single-stage core: accepts one memory request per transaction from the execute stage and runs it on the data bus. Requests are driven by the instruction decoder's `ram_req`/`ram_wr`, with the ALU result as address and rs2 as store data. The unit performs byte-lane steering, alignment checks, load sign/zero extension and a bus timeout. It returns a one-cycle response whose data feeds writeback source LSU.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `bus_req` stays high without `bus_ack`/`bus_err`; 0 disables the timeout. Range 0..255.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request strobe; accepted when `req_valid & req_ready`.
- `req_type` in 4: RISC-V funct3 in [2:0]. [1:0] is width (00 byte, 01 half, 10 word); [2] is unsigned. [3] must be 0.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_ready` out 1: unit idle, can accept a request.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_error` out 1: valid with `rsp_valid`. Set on misaligned access, invalid type, `bus_err` or timeout.
- `bus_req` out 1: bus cycle active; held until ack, err or timeout.
- `bus_we` out 1: write cycle.
- `bus_addr` out 32: word address, with [1:0] = 00.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: transfer complete; `bus_rdata` valid this cycle.
- `bus_err` in 1: bus error.
- `bus_rdata` in 32: read data.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. An accepted valid, aligned request registers all fields, drives the bus outputs and goes to BUS. An accepted invalid or misaligned request goes to RESP with error and issues no bus cycle.
  - BUS: `bus_req`=1.
    - `bus_err` → RESP, error.
    - `bus_ack` → RESP, capture data.
    - Timeout counter reaches `TIMEOUT_CYCLES` → RESP, error.
  - RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- Invalid `req_type`: [3]=1; width 11; load with [2]=1 and width 10 (LWU); store with [2]=1.
- Misalignment: half with addr[0]=1; word with addr[1:0]≠00. Bytes never misalign.
- Byte enables:
  - Byte: `bus_be` = 1<<addr[1:0], `bus_wdata` = {4{wdata[7:0]}}.
  - Half: `bus_be` = 0011 (addr[1]=0) or 1100, `bus_wdata` = {2{wdata[15:0]}}.
  - Word: `bus_be` = 1111, `bus_wdata` = wdata.
- Loads select the lane by addr[1:0], then sign-extend (type[2]=0) or zero-extend (type[2]=1) to 32 bits.
- Priority in BUS: `bus_err` > `bus_ack` > timeout. An ack in the same cycle the counter hits the limit completes successfully.
- `bus_ack`/`bus_err` outside BUS are ignored.
- `req_valid` while not ready is ignored. It is not queued.

## Timing
- Reset values: `req_ready`=1. `rsp_valid`, `rsp_error`, `bus_req`, `bus_we` are 0; `rsp_rdata`, `bus_addr`, `bus_be`, `bus_wdata` are 0. State is IDLE and the counter is 0.
- Cycle 0: request accepted. Cycle 1: `bus_req`=1, with bus outputs registered and stable until completion.
- An ack in cycle k (k≥1) gives `rsp_valid` in cycle k+1. Minimum latency is 2 cycles (zero-wait-state ack in cycle 1).
- `req_ready` is 1 again in cycle k+2. Maximum throughput is one transaction per 3 cycles.
- Error without bus (misaligned or invalid): `rsp_valid`+`rsp_error` in cycle 1, `req_ready` in cycle 2.
- Timeout: the counter clears on entry to BUS and increments each BUS cycle without ack/err. Reaching `TIMEOUT_CYCLES` drops `bus_req` the next cycle, together with `rsp_valid`+`rsp_error`.
- Reset mid-transaction: `bus_req` and `rsp_valid` deassert immediately (asynchronously). No response is produced for the aborted request.

## Test plan
- LB at 0x1003, `bus_rdata`=0x80_00_00_00, ack in cycle 1 → `bus_be`=1000 and `bus_addr`=0x1000. `rsp_rdata`=0xFFFFFF80, `rsp_error`=0, `rsp_valid` in cycle 2.
- LHU at 0x2002, `bus_rdata`=0xBEEF1234, ack after 3 wait states → `bus_be`=1100, `rsp_rdata`=0x0000BEEF, `rsp_valid` 5 cycles after acceptance.
- SB of 0x000000A5 at 0x11, ack in cycle 1 → `bus_we`=1, `bus_be`=0010, `bus_wdata`=0xA5A5A5A5, `rsp_rdata`=0.
- SW at 0x102 → no `bus_req` ever asserted; `rsp_valid`=1 and `rsp_error`=1 in cycle 1. Repeat with `req_type`=0011 (LD): same result.
- LW with `TIMEOUT_CYCLES`=4 and no ack → `bus_req` high for exactly 4 cycles, then `rsp_error`=1. Next, `bus_err` and `bus_ack` in the same cycle → error response.
- Assert `rst` during BUS wait → `bus_req`=0 immediately, no `rsp_valid`, `req_ready`=1. A following SW at 0x0 completes normally.

Source files
------------

// File: rtl/rv32_mod_load_store_unit.sv
`timescale 1ns / 1ps
// rv32_mod_load_store_unit
//
// Load/store unit for the single-stage rv32imc core. Each accepted request
// either runs one data-bus cycle or is rejected without touching the bus. The
// unit steers byte lanes, checks alignment, sign/zero-extends loads and times
// out a stalled bus cycle. A completed transaction produces a one-cycle
// response.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake (accepted when both high)
//   req_type[3:0]            funct3 in [2:0] ([1:0] width, [2] unsigned), [3] must be 0
//   req_wr                   1 = store, 0 = load
//   req_addr, req_wdata      byte address, right-aligned store data
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_error     extended load data (0 for stores/errors), error flag
//   bus_req/bus_we           bus cycle active / write cycle
//   bus_addr, bus_be         word address, byte enables
//   bus_wdata                lane-replicated store data
//   bus_ack, bus_err         transfer complete / bus error
//   bus_rdata                read data, valid with bus_ack
module rv32_mod_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_type,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [8:0] TimeoutLimit = 9'(TIMEOUT_CYCLES);
  localparam bit         TimeoutEn    = (TIMEOUT_CYCLES != 0);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  lane_q, lane_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  // Request decode
  logic [1:0]  req_width;
  logic        type_bad;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  always_comb begin
    req_width  = req_type[1:0];
    type_bad   = req_type[3] || (req_width == 2'b11) ||
                 (!req_wr && req_type[2] && (req_width == 2'b10)) ||
                 (req_wr && req_type[2]);
    misaligned = ((req_width == 2'b01) && req_addr[0]) ||
                 ((req_width == 2'b10) && (req_addr[1:0] != 2'b00));
    unique case (req_width)
      2'b00: begin
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
      end
    endcase
  end

  // Load lane selection and extension, using the fields latched at acceptance
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  always_comb begin
    rdata_shifted = bus_rdata >> {lane_q, 3'b000};
    unique case (type_q[1:0])
      2'b00:   load_data = {{24{~type_q[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_data = {{16{~type_q[2] & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  logic [8:0] cnt_inc;
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    lane_d      = lane_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (type_bad || misaligned) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d     = StBus;
            cnt_d       = 8'd0;
            type_d      = req_type[2:0];
            lane_d      = req_addr[1:0];
            bus_req_d   = 1'b1;
            bus_we_d    = req_wr;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_be_d    = be_calc;
            bus_wdata_d = wdata_calc;
          end
        end
      end
      StBus: begin
        // err beats ack beats timeout
        if (bus_err) begin
          state_d     = StResp;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else if (bus_ack) begin
          state_d     = StResp;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_we_q ? 32'h0 : load_data;
        end else if (TimeoutEn && (cnt_inc == TimeoutLimit)) begin
          state_d     = StResp;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      type_q      <= 3'd0;
      lane_q      <= 2'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      lane_q      <= lane_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
`timescale 1ns / 1ps
module tb_rv32_mod_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_type;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int checks;
  int errors;

  rv32_mod_load_store_unit #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_type  (req_type),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle 1 of the transaction
  task automatic issue(input logic [3:0] t, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_type  = t;
    req_wr    = w;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_type  = 4'h0;
    req_wr    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = 32'h0;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_we", {31'b0, bus_we}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", {28'b0, bus_be}, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // Ack while idle is ignored
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    check("idle_ack_rsp", {31'b0, rsp_valid}, 32'd0);
    check("idle_ack_ready", {31'b0, req_ready}, 32'd1);

    // LB at 0x1003, zero-wait ack
    issue(4'b0000, 1'b0, 32'h0000_1003, 32'h0);
    check("lb_bus_req", {31'b0, bus_req}, 32'd1);
    check("lb_bus_be", {28'b0, bus_be}, 32'h8);
    check("lb_bus_addr", bus_addr, 32'h0000_1000);
    check("lb_bus_we", {31'b0, bus_we}, 32'd0);
    check("lb_ready_c1", {31'b0, req_ready}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h8000_0000;
    step();
    bus_ack = 1'b0;
    check("lb_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lb_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
    check("lb_rsp_error", {31'b0, rsp_error}, 32'd0);
    check("lb_bus_req_c2", {31'b0, bus_req}, 32'd0);
    step();
    check("lb_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    check("lb_ready_c3", {31'b0, req_ready}, 32'd1);

    // LHU at 0x2002, ack after 3 wait states (ack lands when counter hits limit)
    issue(4'b0101, 1'b0, 32'h0000_2002, 32'h0);
    check("lhu_bus_be", {28'b0, bus_be}, 32'hC);
    // Request while busy must be dropped
    req_valid = 1'b1;
    req_type  = 4'b0010;
    req_wr    = 1'b1;
    req_addr  = 32'h0000_0040;
    step();
    req_valid = 1'b0;
    step();
    check("lhu_wait_req", {31'b0, bus_req}, 32'd1);
    check("lhu_wait_be", {28'b0, bus_be}, 32'hC);
    step();
    check("lhu_c4_rsp", {31'b0, rsp_valid}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'hBEEF_1234;
    step();
    bus_ack = 1'b0;
    check("lhu_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lhu_rsp_rdata", rsp_rdata, 32'h0000_BEEF);
    check("lhu_rsp_error", {31'b0, rsp_error}, 32'd0);
    step();
    step();
    check("busy_req_dropped", {31'b0, bus_req}, 32'd0);
    check("busy_req_ready", {31'b0, req_ready}, 32'd1);

    // SB of 0xA5 at 0x11
    issue(4'b0000, 1'b1, 32'h0000_0011, 32'h0000_00A5);
    check("sb_bus_we", {31'b0, bus_we}, 32'd1);
    check("sb_bus_be", {28'b0, bus_be}, 32'h2);
    check("sb_bus_wdata", bus_wdata, 32'hA5A5_A5A5);
    check("sb_bus_addr", bus_addr, 32'h0000_0010);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0;
    check("sb_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("sb_rsp_rdata", rsp_rdata, 32'h0);
    step();

    // SH at 0x22: upper half lanes, replicated data
    issue(4'b0001, 1'b1, 32'h0000_0022, 32'hFFFF_C3D4);
    check("sh_bus_be", {28'b0, bus_be}, 32'hC);
    check("sh_bus_wdata", bus_wdata, 32'hC3D4_C3D4);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();

    // LB at 0x4001, signed byte positive, lane 1
    issue(4'b0000, 1'b0, 32'h0000_4001, 32'h0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1122_7F44;
    step();
    bus_ack = 1'b0;
    check("lb1_rsp_rdata", rsp_rdata, 32'h0000_007F);
    step();

    // SW misaligned at 0x102: no bus cycle, error in cycle 1
    issue(4'b0010, 1'b1, 32'h0000_0102, 32'hDEAD_BEEF);
    check("swmis_bus_req", {31'b0, bus_req}, 32'd0);
    check("swmis_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("swmis_rsp_error", {31'b0, rsp_error}, 32'd1);
    check("swmis_rsp_rdata", rsp_rdata, 32'h0);
    check("swmis_ready_c1", {31'b0, req_ready}, 32'd0);
    step();
    check("swmis_ready_c2", {31'b0, req_ready}, 32'd1);
    check("swmis_bus_req_c2", {31'b0, bus_req}, 32'd0);

    // LD (width 11) is an invalid type
    issue(4'b0011, 1'b0, 32'h0000_0100, 32'h0);
    check("ld_bus_req", {31'b0, bus_req}, 32'd0);
    check("ld_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("ld_rsp_error", {31'b0, rsp_error}, 32'd1);
    step();

    // LWU is an invalid type
    issue(4'b0110, 1'b0, 32'h0000_0100, 32'h0);
    check("lwu_bus_req", {31'b0, bus_req}, 32'd0);
    check("lwu_rsp_error", {31'b0, rsp_error}, 32'd1);
    step();

    // LW with no ack: bus_req high for exactly 4 cycles, then error
    issue(4'b0010, 1'b0, 32'h0000_0200, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_bus_req_c%0d", i), {31'b0, bus_req}, 32'd1);
      check($sformatf("to_rsp_c%0d", i), {31'b0, rsp_valid}, 32'd0);
      step();
    end
    check("to_bus_req_c5", {31'b0, bus_req}, 32'd0);
    check("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("to_rsp_error", {31'b0, rsp_error}, 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    step();

    // bus_err together with bus_ack: error wins
    issue(4'b0010, 1'b0, 32'h0000_0300, 32'h0);
    bus_ack   = 1'b1;
    bus_err   = 1'b1;
    bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    check("errack_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("errack_rsp_error", {31'b0, rsp_error}, 32'd1);
    check("errack_rsp_rdata", rsp_rdata, 32'h0);
    step();

    // Reset during bus wait aborts asynchronously
    issue(4'b0010, 1'b0, 32'h0000_0400, 32'h0);
    step();
    check("rstmid_bus_req_pre", {31'b0, bus_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_bus_req", {31'b0, bus_req}, 32'd0);
    check("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstmid_ready", {31'b0, req_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();
    check("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // SW at 0x0 after reset completes normally
    issue(4'b0010, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    check("sw0_bus_req", {31'b0, bus_req}, 32'd1);
    check("sw0_bus_be", {28'b0, bus_be}, 32'hF);
    check("sw0_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    check("sw0_bus_we", {31'b0, bus_we}, 32'd1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("sw0_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("sw0_rsp_error", {31'b0, rsp_error}, 32'd0);
    check("sw0_rsp_rdata", rsp_rdata, 32'h0);
    step();
    check("sw0_ready", {31'b0, req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
